muldiv_engine: RTL and testbench

MULDIV_ENGINE -- requirements
Module: muldiv_engine

---
 rtl/muldiv_engine.sv | 132 +++++++++++++
 tb/tb_muldiv_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_engine.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Results are computed at accept, held pending, and committed when the busy window expires.
module muldiv_engine #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        hi_reg, hi_next, lo_reg, lo_next;
    logic [31:0]        hi_p_reg, hi_p_next, lo_p_reg, lo_p_next;
    logic               commit_en_reg, commit_en_next;

    logic        accept;
    logic        is_signed;
    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quotient, remainder;

    assign busy = (state_reg == RUN);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    assign accept    = start && !flush && !busy && (op != 3'd0) && (op != 3'd7);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    // One 64x64 multiplier serves both flavours: the extension bits pick signedness.
    assign mul_a   = {{32{is_signed & d1[31]}}, d1};
    assign mul_b   = {{32{is_signed & d2[31]}}, d2};
    assign product = mul_a * mul_b;

    // Signed division via magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned,
    // so the -2^31 / -1 case wraps back to 0x80000000 with remainder 0 naturally.
    assign a_neg     = is_signed & d1[31];
    assign b_neg     = is_signed & d2[31];
    assign a_mag     = a_neg ? (32'd0 - d1) : d1;
    assign b_mag     = b_neg ? (32'd0 - d2) : d2;
    assign div_b     = (d2 == 32'd0) ? 32'd1 : b_mag;
    assign q_mag     = a_mag / div_b;
    assign r_mag     = a_mag % div_b;
    assign quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign remainder = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        hi_p_next      = hi_p_reg;
        lo_p_next      = lo_p_reg;
        commit_en_next = commit_en_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            hi_p_next      = product[63:32];
                            lo_p_next      = product[31:0];
                            commit_en_next = 1'b1;
                            cnt_next       = CNT_W'(MULT_CYCLES);
                            state_next     = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_p_next      = remainder;
                            lo_p_next      = quotient;
                            commit_en_next = (d2 != 32'd0);
                            cnt_next       = CNT_W'(DIV_CYCLES);
                            state_next     = RUN;
                        end
                        OP_MTHI: hi_next = d1;
                        OP_MTLO: lo_next = d1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    // A zero divisor still burns the full latency but leaves HI/LO alone.
                    if (commit_en_reg) begin
                        hi_next = hi_p_reg;
                        lo_next = lo_p_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            hi_p_reg      <= '0;
            lo_p_reg      <= '0;
            commit_en_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            hi_p_reg      <= hi_p_next;
            lo_p_reg      <= lo_p_next;
            commit_en_reg <= commit_en_next;
        end
    end
endmodule

// File: tb/tb_muldiv_engine.sv
// Scoreboard bench for muldiv_engine: a per-cycle reference model queues the expected
// hi/lo/busy after every edge, and a negedge monitor pops and compares.
module tb_muldiv_engine;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] d1 = '0, d2 = '0;
    logic        busy;
    logic [31:0] hi, lo;

    muldiv_engine #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_rem = 0;
    bit          m_commit = 0;

    task automatic model_step();
        longint      sa, sb, sq, sr;
        logic [63:0] pu;
        exp_t        e;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_rem = 0; m_commit = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_commit) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start && !flush && op >= 3'd1 && op <= 3'd6) begin
            sa = longint'($signed(d1));
            sb = longint'($signed(d2));
            case (op)
                3'd1: begin
                    sq = sa * sb;
                    m_phi = sq[63:32]; m_plo = sq[31:0]; m_rem = MC; m_commit = 1;
                end
                3'd2: begin
                    pu = {32'd0, d1} * {32'd0, d2};
                    m_phi = pu[63:32]; m_plo = pu[31:0]; m_rem = MC; m_commit = 1;
                end
                3'd3: begin
                    m_rem = DC;
                    m_commit = (d2 != 0);
                    if (d2 != 0) begin
                        sq = sa / sb; sr = sa % sb;
                        m_plo = sq[31:0]; m_phi = sr[31:0];
                    end
                end
                3'd4: begin
                    m_rem = DC;
                    m_commit = (d2 != 0);
                    if (d2 != 0) begin
                        m_plo = d1 / d2; m_phi = d1 % d2;
                    end
                end
                3'd5: m_hi = d1;
                default: m_lo = d1;
            endcase
        end
        e.tag = cyc + 1; e.hi = m_hi; e.lo = m_lo; e.busy = (m_rem > 0);
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic f, input logic r);
        start = s; op = o; d1 = a; d2 = b; flush = f; reset = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        tick(1'b1, o, a, b, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (hi !== e.hi || lo !== e.lo || busy !== e.busy) begin
                errors++;
                $display("FAIL state@cyc%0d: got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=%b",
                         e.tag, hi, lo, busy, e.hi, e.lo, e.busy);
            end
            $display("cyc %0d: hi=%h lo=%h busy=%b", e.tag, hi, lo, busy);
        end
    end

    initial begin
        tick(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        idle(1);

        issue(3'd1, 32'hFFFF_FFFF, 32'd2);             // mult -> FFFFFFFF_FFFFFFFE
        idle(MC);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);             // multu, back-to-back
        idle(MC);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);             // div -7/2 -> q=-3, r=-1
        idle(DC);
        issue(3'd4, 32'd7, 32'd2);                     // divu 7/2 -> q=3, r=1
        idle(DC);
        issue(3'd5, 32'h1234_5678, '0);                // mthi
        idle(1);
        tick(1'b1, 3'd6, 32'hDEAD_BEEF, '0, 1'b1, 1'b0); // flushed mtlo
        tick(1'b1, 3'd1, 32'd3, 32'd3, 1'b1, 1'b0);      // flushed mult
        idle(1);

        issue(3'd1, 32'h0001_0003, 32'hFFFF_FFF0);     // mult in flight
        idle(1);
        issue(3'd3, 32'd100, 32'd7);                   // busy cycle 2: ignored
        tick(1'b1, 3'd5, 32'h5555_5555, '0, 1'b1, 1'b0); // busy cycle 3 with flush
        idle(MC);

        issue(3'd3, 32'd1000, 32'd3);                  // div in flight
        idle(3);
        tick(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);          // reset at busy cycle 4
        idle(DC + 2);

        issue(3'd5, 32'hA, '0);
        issue(3'd6, 32'hB, '0);
        issue(3'd4, 32'h1234, 32'd0);                  // divu by zero keeps A/B
        idle(DC + 1);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);     // signed overflow case
        idle(DC + 1);

        for (int i = 0; i < 2000; i++) begin
            tick($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rnd_word(), rnd_word(),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end
        idle(DC + 2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
